// File: rtl/fibo_pkg.sv
// fibo_pkg: shared definitions for the Fibonacci stream generator.
//   state_t         - control FSM states (IDLE, RUN, FIN)
//   DEF_WIDTH/CNT_W - default term width and term-counter width
//   *_SEED*         - preset seeds for Fibonacci (0,1) and Lucas (2,1)
package fibo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 8;

  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;
  localparam int LUC_SEED0 = 2;
  localparam int LUC_SEED1 = 1;

endpackage

// File: rtl/fibo_term_pair.sv
// fibo_term_pair: holds the two most recent terms of the recurrence.
//   i_clk, i_rst      - clock, synchronous active-high reset
//   i_load            - load a/b from the seeds and clear the wrap flags
//   i_adv             - advance one step: a<=b, b<=a+b (mod 2^WIDTH)
//   i_seed0, i_seed1  - seed terms t[0], t[1]
//   o_a, o_wa         - current term and its wrapped flag
// With neither i_load nor i_adv asserted, all state holds.
module fibo_term_pair
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_seed0,
  input  logic [WIDTH-1:0] i_seed1,
  output logic [WIDTH-1:0] o_a,
  output logic             o_wa
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_wa;
  logic             r_wb;
  logic [WIDTH:0]   w_sum;

  // One extra bit captures the carry out of the modulo addition.
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a  <= '0;
      r_b  <= '0;
      r_wa <= 1'b0;
      r_wb <= 1'b0;
    end else if (i_load) begin
      r_a  <= i_seed0;
      r_b  <= i_seed1;
      r_wa <= 1'b0;
      r_wb <= 1'b0;
    end else if (i_adv) begin
      r_a  <= r_b;
      r_wa <= r_wb;
      r_b  <= w_sum[WIDTH-1:0];
      // Once any ancestor term wrapped, every later term's true value is
      // also out of range, so the flag propagates forward.
      r_wb <= w_sum[WIDTH] | r_wa | r_wb;
    end
  end

  assign o_a  = r_a;
  assign o_wa = r_wa;

endmodule

// File: rtl/fibo_stream_gen.sv
// fibo_stream_gen: emits COUNT terms of t[i+2]=t[i+1]+t[i] from SEED0/SEED1
// on a valid/ready stream.
//   CLK, RST          - clock, synchronous active-high reset
//   START             - run request, accepted only in IDLE
//   COUNT, SEED0/1    - run length and seeds, sampled on accepted START
//   OUT_DATA/VALID/READY/LAST/WRAP - output term stream
//   BUSY              - run in progress
//   DONE              - one-cycle pulse after the last transfer
//   OVF               - sticky: a wrapped term was transferred this run
//   DBG_STATE         - current FSM state, for observation only
//
// Handshake: a term transfers on a rising edge where OUT_VALID and
// OUT_READY are both 1. While OUT_VALID=1 and OUT_READY=0 the term and all
// of its side-band flags hold; OUT_VALID never drops without a transfer
// (except on RST).
module fibo_stream_gen
  import fibo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  input  logic [WIDTH-1:0] SEED0,
  input  logic [WIDTH-1:0] SEED1,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST,
  output logic             OUT_WRAP,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [1:0]       DBG_STATE
);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_ovf;

  logic             w_load;
  logic             w_xfer;
  logic             w_last;
  logic [WIDTH-1:0] w_a;
  logic             w_wa;

  assign w_load = (r_state == IDLE) && START;
  assign w_xfer = (r_state == RUN) && OUT_READY;
  assign w_last = (r_state == RUN) && (r_remaining == CNT_W'(1));

  fibo_term_pair #(
    .WIDTH (WIDTH)
  ) u_pair (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_adv   (w_xfer),
    .i_seed0 (SEED0),
    .i_seed1 (SEED1),
    .o_a     (w_a),
    .o_wa    (w_wa)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_remaining <= COUNT;
            r_ovf       <= 1'b0;
            r_state     <= (COUNT == '0) ? FIN : RUN;
          end
        end
        RUN: begin
          if (w_xfer) begin
            // Leaving RUN on the last term keeps remaining from reaching
            // below zero, so it never wraps.
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_wa) r_ovf <= 1'b1;
            if (w_last) r_state <= FIN;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are decodes of registered state only; no input-to-output paths.
  assign OUT_DATA  = w_a;
  assign OUT_WRAP  = w_wa;
  assign OUT_VALID = (r_state == RUN);
  assign OUT_LAST  = w_last;
  assign BUSY      = (r_state == RUN);
  assign DONE      = (r_state == FIN);
  assign OVF       = r_ovf;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_fibo_stream_gen.sv
module tb_fibo_stream_gen;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vec  = 0;
  int miss = 0;

  // ---------------- 16-bit instance ----------------
  logic        rst16, start16, ready16;
  logic [7:0]  count16;
  logic [15:0] seed0_16, seed1_16, data16;
  logic        valid16, last16, wrap16, busy16, done16, ovf16;
  logic [1:0]  st16;

  fibo_stream_gen #(.WIDTH(16), .CNT_W(8)) dut16 (
    .CLK(CLK), .RST(rst16), .START(start16), .COUNT(count16),
    .SEED0(seed0_16), .SEED1(seed1_16), .OUT_DATA(data16),
    .OUT_VALID(valid16), .OUT_READY(ready16), .OUT_LAST(last16),
    .OUT_WRAP(wrap16), .BUSY(busy16), .DONE(done16), .OVF(ovf16),
    .DBG_STATE(st16)
  );

  // ---------------- 8-bit instance ----------------
  logic        rst8, start8, ready8;
  logic [7:0]  count8;
  logic [7:0]  seed0_8, seed1_8, data8;
  logic        valid8, last8, wrap8, busy8, done8, ovf8;
  logic [1:0]  st8;

  fibo_stream_gen #(.WIDTH(8), .CNT_W(8)) dut8 (
    .CLK(CLK), .RST(rst8), .START(start8), .COUNT(count8),
    .SEED0(seed0_8), .SEED1(seed1_8), .OUT_DATA(data8),
    .OUT_VALID(valid8), .OUT_READY(ready8), .OUT_LAST(last8),
    .OUT_WRAP(wrap8), .BUSY(busy8), .DONE(done8), .OVF(ovf8),
    .DBG_STATE(st8)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {last, wrap, data}
  logic [17:0] exp16_q[$];
  logic [9:0]  exp8_q[$];

  int ref16 = -10, ref8 = -10;
  int done_cnt16 = 0, done_cnt8 = 0;
  int xfer_cnt16 = 0, xfer_cnt8 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 16-bit instance, with stall-stability checking.
  logic        stall16 = 1'b0;
  logic [18:0] held16;
  logic        prev_done16 = 1'b0;
  always @(negedge CLK) begin
    logic [17:0] e;
    if (stall16)
      chk("d16 stall hold", {last16, wrap16, valid16, data16}, held16);
    stall16 = valid16 && !ready16;
    held16  = {last16, wrap16, valid16, data16};
    if (valid16 && ready16) begin
      xfer_cnt16++;
      if (exp16_q.size() == 0) begin
        chk("d16 unexpected term", {wrap16, last16, data16}, 64'hFFFF_FFFF);
      end else begin
        e = exp16_q.pop_front();
        chk("d16 data", data16, e[15:0]);
        chk("d16 wrap", wrap16, e[16]);
        chk("d16 last", last16, e[17]);
      end
      if (last16) ref16 = cyc;
    end
    if (done16) begin
      done_cnt16++;
      chk("d16 done timing", cyc, ref16 + 1);
      chk("d16 done width", prev_done16, 0);
    end
    prev_done16 = done16;
  end

  logic prev_done8 = 1'b0;
  always @(negedge CLK) begin
    logic [9:0] e;
    if (valid8 && ready8) begin
      xfer_cnt8++;
      if (exp8_q.size() == 0) begin
        chk("d8 unexpected term", {wrap8, last8, data8}, 64'hFFFF_FFFF);
      end else begin
        e = exp8_q.pop_front();
        chk("d8 data", data8, e[7:0]);
        chk("d8 wrap", wrap8, e[8]);
        chk("d8 last", last8, e[9]);
      end
      if (last8) ref8 = cyc;
    end
    if (done8) begin
      done_cnt8++;
      chk("d8 done timing", cyc, ref8 + 1);
      chk("d8 done width", prev_done8, 0);
    end
    prev_done8 = done8;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start16_t(input logic [7:0] c, input logic [15:0] s0, input logic [15:0] s1);
    start16 = 1'b1; count16 = c; seed0_16 = s0; seed1_16 = s1;
    tick();
    if (c == 0) ref16 = cyc - 1;
    start16 = 1'b0; count16 = 8'hAA; seed0_16 = 16'h5555; seed1_16 = 16'h3333;
  endtask

  task automatic start8_t(input logic [7:0] c, input logic [7:0] s0, input logic [7:0] s1);
    start8 = 1'b1; count8 = c; seed0_8 = s0; seed1_8 = s1;
    tick();
    if (c == 0) ref8 = cyc - 1;
    start8 = 1'b0; count8 = 8'h55; seed0_8 = 8'h77; seed1_8 = 8'h66;
  endtask

  task automatic wait_done16(input int limit);
    int c0 = done_cnt16;
    int n = 0;
    while (done_cnt16 == c0 && n < limit) begin tick(); n++; end
    if (done_cnt16 == c0) begin
      vec++; miss++;
      $display("FAIL d16 done timeout: got no DONE expected DONE within %0d cycles", limit);
    end
  endtask

  task automatic wait_done8(input int limit);
    int c0 = done_cnt8;
    int n = 0;
    while (done_cnt8 == c0 && n < limit) begin tick(); n++; end
    if (done_cnt8 == c0) begin
      vec++; miss++;
      $display("FAIL d8 done timeout: got no DONE expected DONE within %0d cycles", limit);
    end
  endtask

  // ---------------- directed vectors ----------------
  int fib8_16[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
  int luc5[5]    = '{2, 1, 3, 4, 7};
  int fib15_8[15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};

  initial begin
    int c0, x0;
    rst16 = 1'b1; start16 = 1'b0; ready16 = 1'b0; count16 = '0; seed0_16 = '0; seed1_16 = '0;
    rst8  = 1'b1; start8  = 1'b0; ready8  = 1'b0; count8  = '0; seed0_8  = '0; seed1_8  = '0;
    repeat (3) tick();
    rst16 = 1'b0; rst8 = 1'b0;
    @(negedge CLK);
    chk("reset d16 outputs", {data16, valid16, last16, wrap16, busy16, done16, ovf16, st16}, 0);
    chk("reset d8 outputs",  {data8, valid8, last8, wrap8, busy8, done8, ovf8, st8}, 0);

    // 1: Fibonacci, 8 terms, consumer always ready
    foreach (fib8_16[i]) exp16_q.push_back({(i == 7), 1'b0, 16'(fib8_16[i])});
    ready16 = 1'b1;
    start16_t(8, 16'(FIB_SEED0_T), 16'(FIB_SEED1_T));
    wait_done16(40);
    chk("t1 queue drained", exp16_q.size(), 0);
    chk("t1 ovf", ovf16, 0);

    // 2: Lucas, 5 terms, ready pattern 1,0,0 repeating
    foreach (luc5[i]) exp16_q.push_back({(i == 4), 1'b0, 16'(luc5[i])});
    c0 = done_cnt16; x0 = xfer_cnt16;
    start16_t(5, 16'd2, 16'd1);
    for (int i = 0; i < 20; i++) begin
      ready16 = (i % 3 == 0);
      tick();
    end
    ready16 = 1'b1;
    chk("t2 done count", done_cnt16 - c0, 1);
    chk("t2 transfers", xfer_cnt16 - x0, 5);
    chk("t2 queue drained", exp16_q.size(), 0);

    // 4: COUNT=0 finishes immediately with no terms
    start16_t(0, 16'd3, 16'd4);
    @(negedge CLK);
    chk("t4 done", done16, 1);
    chk("t4 valid", valid16, 0);
    chk("t4 busy", busy16, 0);
    tick(); tick();
    chk("t4 valid after", valid16, 0);

    // 5a: START during a run is ignored
    foreach (fib8_16[i]) exp16_q.push_back({(i == 7), 1'b0, 16'(fib8_16[i])});
    x0 = xfer_cnt16;
    start16_t(8, 16'd0, 16'd1);
    tick(); tick(); tick();
    start16_t(2, 16'd5, 16'd5);
    wait_done16(40);
    chk("t5 transfers", xfer_cnt16 - x0, 8);
    chk("t5 queue drained", exp16_q.size(), 0);

    // 5b: RST mid-run aborts without DONE
    exp16_q.push_back({1'b0, 1'b0, 16'd0});
    exp16_q.push_back({1'b0, 1'b0, 16'd1});
    c0 = done_cnt16;
    start16_t(8, 16'd0, 16'd1);
    tick();
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    @(negedge CLK);
    chk("t5 rst outputs", {data16, valid16, last16, wrap16, busy16, done16, ovf16, st16}, 0);
    repeat (3) @(negedge CLK);
    chk("t5 no done after rst", done_cnt16 - c0, 0);
    chk("t5 rst queue drained", exp16_q.size(), 0);

    // 5c: fresh run after reset
    exp16_q.push_back({1'b0, 1'b0, 16'd0});
    exp16_q.push_back({1'b0, 1'b0, 16'd1});
    exp16_q.push_back({1'b1, 1'b0, 16'd1});
    start16_t(3, 16'd0, 16'd1);
    wait_done16(20);
    chk("t5c queue drained", exp16_q.size(), 0);

    // MSB-set seeds: 0x8000+0x8000 wraps to 0
    exp16_q.push_back({1'b0, 1'b0, 16'h8000});
    exp16_q.push_back({1'b0, 1'b0, 16'h8000});
    exp16_q.push_back({1'b1, 1'b1, 16'h0000});
    start16_t(3, 16'h8000, 16'h8000);
    wait_done16(20);
    chk("msb ovf", ovf16, 1);

    // 3: 8-bit wrap on the 15th term
    foreach (fib15_8[i]) exp8_q.push_back({(i == 14), (i == 14), 8'(fib15_8[i])});
    ready8 = 1'b1;
    start8_t(15, 8'd0, 8'd1);
    @(negedge CLK);
    chk("t3 ovf cleared", ovf8, 0);
    wait_done8(40);
    chk("t3 queue drained", exp8_q.size(), 0);
    chk("t3 ovf set", ovf8, 1);
    repeat (4) tick();
    chk("t3 ovf sticky", ovf8, 1);

    // 6: single term
    exp8_q.push_back({1'b1, 1'b0, 8'd7});
    start8_t(1, 8'd7, 8'd9);
    @(negedge CLK);
    chk("t6 ovf cleared", ovf8, 0);
    wait_done8(20);
    chk("t6 queue drained", exp8_q.size(), 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  localparam int FIB_SEED0_T = fibo_pkg::FIB_SEED0;
  localparam int FIB_SEED1_T = fibo_pkg::FIB_SEED1;

endmodule

// File: doc/fibo_stream_gen.md
Name: fibo_stream_gen

Overview:
- Parametrised successor to the fixed 4-bit Fibonacci controller/datapath pair.
- Generates COUNT terms of a generalised Fibonacci recurrence, t[i+2] = t[i+1] + t[i], from programmable seeds. Seeds 0,1 give Fibonacci; seeds 2,1 give Lucas.
- Emits one term per handshake on a valid/ready output stream, with a last-term marker, a completion pulse and overflow reporting.
- Sits between the sequence-request logic and the result memory/consumer.

Parameters:
- WIDTH, 16, term width in bits; all arithmetic is modulo 2^WIDTH.
- CNT_W, 8, width of COUNT and the internal remaining-term counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request pulse; accepted only in IDLE.
- COUNT  input  CNT_W  number of terms to emit; sampled on an accepted START.
- SEED0  input  WIDTH  term t[0]; sampled on an accepted START.
- SEED1  input  WIDTH  term t[1]; sampled on an accepted START.
- OUT_DATA  output  WIDTH  current term.
- OUT_VALID  output  1  OUT_DATA holds a valid term.
- OUT_READY  input  1  consumer accepts the term; a transfer occurs when OUT_VALID and OUT_READY are both 1.
- OUT_LAST  output  1  current term is the final term of the run.
- OUT_WRAP  output  1  current term's true value exceeded 2^WIDTH-1.
- BUSY  output  1  a run is in progress (state RUN).
- DONE  output  1  one-cycle completion pulse.
- OVF  output  1  sticky flag: at least one wrapped term was transferred this run.

Behaviour:
- Reset: state=IDLE; OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, OUT_WRAP=0, BUSY=0, DONE=0, OVF=0; internal registers a, b, remaining and wrap flags all 0. RST mid-run aborts the run with no DONE pulse. The next accepted START behaves as a fresh run.
- States:
  - IDLE: waits for START.
  - RUN: emits terms.
  - FIN: DONE=1 for exactly one cycle, then returns to IDLE.
- IDLE with START=1 at edge t:
  - Load a=SEED0, b=SEED1, remaining=COUNT; clear OVF; clear wrap flags (wa=0, wb=0).
  - If COUNT==0: go to FIN. DONE is high in cycle t+1; OUT_VALID is never asserted.
  - Otherwise: go to RUN. OUT_VALID=1 from cycle t+1 with OUT_DATA=SEED0.
- RUN outputs: OUT_DATA=a, OUT_WRAP=wa, OUT_LAST=(remaining==1), OUT_VALID=1, BUSY=1.
- Transfer in RUN:
  - a<=b; wa<=wb; b<=(a+b) mod 2^WIDTH; wb<=carry_out(a+b) | wa | wb.
  - remaining<=remaining-1.
  - If OUT_WRAP=1, set OVF.
  - If OUT_LAST=1, go to FIN.
- Stall: while OUT_VALID=1 and OUT_READY=0, all outputs and internal state hold.
- Latency: one term per cycle when OUT_READY is held at 1. DONE arrives one cycle after the last transfer.
- START in RUN or FIN is ignored; COUNT and seed changes during a run have no effect.
- FIN: OUT_VALID=0, BUSY=0, DONE=1. OVF holds its value through FIN and IDLE until the next accepted START.
- Seeds are unconstrained, including 0,0 (all-zero sequence) and seeds with the MSB set.
- COUNT=1: a single term (SEED0) with OUT_LAST=1. COUNT=2^CNT_W-1 is legal; remaining never wraps.

Decomposition:
- Package fibo_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - default WIDTH and CNT_W constants;
  - preset seed constants FIB_SEED0=0, FIB_SEED1=1, LUC_SEED0=2, LUC_SEED1=1.
- Sub-module fibo_term_pair contains a, b, wa and wb, the adder with carry, and the load/advance/hold controls.
- The top level contains the FSM, the remaining counter, the handshake logic and OVF.

Test Plan:
1. WIDTH=16, seeds 0,1, COUNT=8, OUT_READY=1 -> terms 0,1,1,2,3,5,8,13 on consecutive cycles. OUT_LAST only on 13. DONE one cycle later. OVF=0.
2. Seeds 2,1, COUNT=5, OUT_READY toggled 1,0,0,1,... -> terms 2,1,3,4,7. Each term is held stable through stalls. Exactly 5 transfers.
3. WIDTH=8, seeds 0,1, COUNT=15 -> terms 0 through 13 equal 0..233 with OUT_WRAP=0. The 15th term is 121 (377 mod 256) with OUT_WRAP=1. OVF=1 after that transfer and stays 1 until the next START.
4. COUNT=0 -> DONE high one cycle after START. OUT_VALID stays 0. BUSY stays 0.
5. START pulsed again after 3 of COUNT=8 transfers -> ignored; the run completes with 8 terms. Then RST asserted mid-run of a second job -> next cycle all outputs 0, no DONE. A new START with COUNT=3 yields 0,1,1.
6. COUNT=1, seeds 7,9 -> a single term 7 with OUT_LAST=1, then DONE.
